// File: rtl/mmio_tx_fifo_pkg.sv
// Shared definitions for the memory-mapped transmit FIFO: register offsets,
// STATUS/CTRL bit positions and a helper that packs the STATUS word.
package mmio_tx_fifo_pkg;

    // Data path width of the core store port and FIFO storage
    localparam int DATA_W = 32;

    // Byte offsets inside the 16-byte register window
    localparam logic [3:0] OFS_DATA   = 4'h0;
    localparam logic [3:0] OFS_STATUS = 4'h4;
    localparam logic [3:0] OFS_CTRL   = 4'h8;
    localparam logic [3:0] OFS_RSVD   = 4'hC;

    // STATUS register layout
    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 8;

    // CTRL register layout
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;

    // Assemble the STATUS word; every bit not named here reads as zero
    function automatic logic [DATA_W-1:0] pack_status(
        input logic                  full,
        input logic                  empty,
        input logic                  ovf,
        input logic [ST_COUNT_W-1:0] count
    );
        logic [DATA_W-1:0] s;
        s                                = {DATA_W{1'b0}};
        s[ST_FULL_BIT]                   = full;
        s[ST_EMPTY_BIT]                  = empty;
        s[ST_OVF_BIT]                    = ovf;
        s[ST_COUNT_LSB +: ST_COUNT_W]    = count;
        return s;
    endfunction

endpackage

// File: rtl/mmio_tx_fifo_fifo_mem.sv
// DEPTH x 32 storage for the transmit FIFO. Synchronous write port,
// asynchronous read at the read pointer so the head word is visible
// without an extra cycle. Contents are intentionally not reset.
module fifo_mem
    import mmio_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Capture an accepted push into the slot addressed by the write pointer
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mmio_tx_fifo.sv
// Memory-mapped transmit FIFO on the MIPS data-memory port.
// Decodes a 16-byte window at BASE_ADDR (DATA / STATUS / CTRL / reserved),
// buffers stored words and drains them over a valid/ready handshake.
// Register reads are combinational so single-cycle loads complete in place.
// Optional feature: define MMIO_TX_FIFO_IRQ_EN to add a CTRL irq-enable bit
// and a registered `irq` output that signals "FIFO empty".
module mmio_tx_fifo #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic        sel,
    output logic [31:0] readdata,
    output logic [31:0] tx_data,
    output logic        tx_valid,
`ifdef MMIO_TX_FIFO_IRQ_EN
    output logic        irq,
`endif
    input  logic        tx_ready
);

    import mmio_tx_fifo_pkg::*;

    localparam int                 PTR_W   = $clog2(DEPTH);
    localparam int                 CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0]   PTR_ZERO = {PTR_W{1'b0}};

    // Decode and request strobes
    logic              sel_s;
    logic [3:0]        ofs_s;
    logic              wr_data_s;
    logic              wr_ctrl_s;
    logic              flush_s;
    logic              clr_ovf_s;
    logic              pop_s;
    logic              push_ok_s;
    logic              ovf_set_s;
    logic              full_s;
    logic              empty_s;

    // FIFO state
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              ovf_r;

    // Read path
    logic [DATA_W-1:0] head_s;
    logic [DATA_W-1:0] status_s;
    logic [DATA_W-1:0] ctrl_rd_s;
    logic [DATA_W-1:0] readdata_s;
    logic [ST_COUNT_W-1:0] count8_s;

    // Address bits [1:0] and the store data bits with no register meaning
    // are deliberately ignored; fold them here so that is explicit.
    logic              unused_s;
    assign unused_s = ^{aluout[1:0], writedata};

    assign sel_s     = (aluout[31:4] == BASE_ADDR[31:4]);
    assign ofs_s     = {aluout[3:2], 2'b00};
    assign wr_data_s = memwrite & sel_s & (ofs_s == OFS_DATA);
    assign wr_ctrl_s = memwrite & sel_s & (ofs_s == OFS_CTRL);
    assign flush_s   = wr_ctrl_s & writedata[CTRL_FLUSH_BIT];
    assign clr_ovf_s = wr_ctrl_s & writedata[CTRL_CLR_OVF_BIT];

    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == CNT_ZERO);
    assign tx_valid  = ~empty_s;
    assign pop_s     = tx_valid & tx_ready;

    // A full FIFO still takes a push when the head leaves in the same cycle;
    // a flush swallows any same-cycle push without touching overflow.
    assign push_ok_s = wr_data_s & ~flush_s & (~full_s | pop_s);
    assign ovf_set_s = wr_data_s & ~flush_s & full_s & ~pop_s;

    fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok_s),
        .waddr (wr_ptr_r),
        .wdata (writedata),
        .raddr (rd_ptr_r),
        .rdata (head_s)
    );

    // Pointer and occupancy bookkeeping; flush wins over push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (clr_ovf_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

`ifdef MMIO_TX_FIFO_IRQ_EN
    logic irq_en_r;
    logic irq_r;

    // Interrupt enable follows bit2 of every CTRL write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_r <= 1'b0;
        end else if (wr_ctrl_s) begin
            irq_en_r <= writedata[CTRL_IRQ_EN_BIT];
        end else begin
            irq_en_r <= irq_en_r;
        end
    end

    // Registered "FIFO drained" interrupt, one cycle behind its conditions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= empty_s & irq_en_r;
        end
    end

    assign irq = irq_r;

    // CTRL read-back exposes only the irq enable
    always_comb begin
        ctrl_rd_s                  = {DATA_W{1'b0}};
        ctrl_rd_s[CTRL_IRQ_EN_BIT] = irq_en_r;
    end
`else
    // Without the interrupt option CTRL reads back as zero
    always_comb begin
        ctrl_rd_s = {DATA_W{1'b0}};
    end
`endif

    // Count is zero-extended into an 8-bit STATUS field
    assign count8_s = ST_COUNT_W'(count_r);
    assign status_s = pack_status(full_s, empty_s, ovf_r, count8_s);

    // Register read mux; anything outside the window or unreadable is zero
    always_comb begin
        readdata_s = {DATA_W{1'b0}};
        if (sel_s) begin
            case (ofs_s)
                OFS_DATA:   readdata_s = {DATA_W{1'b0}};
                OFS_STATUS: readdata_s = status_s;
                OFS_CTRL:   readdata_s = ctrl_rd_s;
                OFS_RSVD:   readdata_s = {DATA_W{1'b0}};
                default:    readdata_s = {DATA_W{1'b0}};
            endcase
        end else begin
            readdata_s = {DATA_W{1'b0}};
        end
    end

    assign sel      = sel_s;
    assign readdata = readdata_s;
    // Head word is only presented while something is queued
    assign tx_data  = empty_s ? {DATA_W{1'b0}} : head_s;

endmodule

// File: tb/tb_mmio_tx_fifo.sv
// Scoreboard bench for mmio_tx_fifo: stores queue their expected delivery,
// a negedge monitor pops and compares every handshake on the tx side.
module tb_mmio_tx_fifo;

    localparam logic [31:0] A_DATA = 32'hFFFF_FF00;
    localparam logic [31:0] A_STAT = 32'hFFFF_FF04;
    localparam logic [31:0] A_CTRL = 32'hFFFF_FF08;
    localparam logic [31:0] A_RSVD = 32'hFFFF_FF0C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] aluout = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic        tx_ready = 1'b0;
    logic        sel;
    logic [31:0] readdata;
    logic [31:0] tx_data;
    logic        tx_valid;
`ifdef MMIO_TX_FIFO_IRQ_EN
    logic        irq;
`endif

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q [$];

    mmio_tx_fifo #(
        .DEPTH     (8),
        .BASE_ADDR (32'hFFFF_FF00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .sel       (sel),
        .readdata  (readdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
`ifdef MMIO_TX_FIFO_IRQ_EN
        .irq       (irq),
`endif
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
        writedata = 32'h0;
    endtask

    task automatic push_word(input logic [31:0] d);
        exp_q.push_back(d);
        store(A_DATA, d);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] want);
        aluout = a;
        #1;
        chk(name, readdata, want);
    endtask

    task automatic drain(input string name, input int want_cycles);
        int cycles;
        cycles   = 0;
        tx_ready = 1'b1;
        while (tx_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        tx_ready = 1'b0;
        chk(name, 32'(cycles), 32'(want_cycles));
    endtask

    // Monitor: each handshake seen mid-cycle completes at the next rising edge
    always @(negedge clk) begin
        if (reset && tx_valid && tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got=%h want=none", tx_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    bad++;
                    $display("FAIL tx_data: got=%h want=%h", tx_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(tx_valid), 32'h0);
        chk("rst_data", tx_data, 32'h0);
        rd("rst_status", A_STAT, 32'h0000_0002);
        @(negedge clk) reset = 1'b1;
        tick();
        aluout = A_STAT;
        #1;
        chk("sel_in", 32'(sel), 32'h1);
        aluout = 32'h1000_0004;
        #1;
        chk("sel_out", 32'(sel), 32'h0);
        chk("rd_out", readdata, 32'h0);

        // Fill with the consumer stalled
        for (int i = 0; i < 8; i++) begin
            push_word(32'h0000_00A0 + 32'(i));
        end
        rd("full_status", A_STAT, 32'h0000_0801);
        chk("full_valid", 32'(tx_valid), 32'h1);
        chk("full_head", tx_data, 32'h0000_00A0);
        rd("data_rd0", A_DATA, 32'h0);
        tick();
        rd("ctrl_rd0", A_CTRL, 32'h0);
        rd("rsvd_rd0", A_RSVD, 32'h0);

        // Ninth store overflows and is dropped; CTRL bit1 clears the flag
        store(A_DATA, 32'h0000_00EE);
        rd("ovf_status", A_STAT, 32'h0000_0805);
        store(A_CTRL, 32'h0000_0002);
        rd("ovf_clr", A_STAT, 32'h0000_0801);

        // Full FIFO with a pop in the same cycle accepts the store
        tx_ready = 1'b1;
        exp_q.push_back(32'h0000_00BB);
        store(A_DATA, 32'h0000_00BB);
        rd("fullpop_status", A_STAT, 32'h0000_0801);
        drain("fullpop_drain", 8);
        rd("drained_status", A_STAT, 32'h0000_0002);
        chk("drained_q", 32'(exp_q.size()), 32'h0);

        // Back-to-back push and pop
        tx_ready = 1'b1;
        push_word(32'h0000_0011);
        push_word(32'h0000_0022);
        push_word(32'h0000_0033);
        rd("stream_status", A_STAT, 32'h0000_0100);
        drain("stream_drain", 1);

        // Flush racing a pop: head is delivered, the rest is discarded
        push_word(32'h0000_00C1);
        push_word(32'h0000_00C2);
        push_word(32'h0000_00C3);
        tx_ready = 1'b1;
        store(A_CTRL, 32'h0000_0001);
        tx_ready = 1'b0;
        chk("flush_left", 32'(exp_q.size()), 32'h2);
        exp_q.delete();
        chk("flush_valid", 32'(tx_valid), 32'h0);
        rd("flush_status", A_STAT, 32'h0000_0002);

        // Ignored address bits, out-of-window and read-only writes
        exp_q.push_back(32'h0000_0077);
        store(A_DATA + 32'h1, 32'h0000_0077);
        store(32'h1000_0000, 32'h0000_0099);
        store(A_RSVD, 32'h0000_0099);
        store(A_STAT, 32'h0000_0099);
        rd("misc_status", A_STAT, 32'h0000_0100);
        chk("misc_head", tx_data, 32'h0000_0077);
        drain("misc_drain", 1);

`ifdef MMIO_TX_FIFO_IRQ_EN
        // Interrupt on empty, one cycle behind enable and behind a push
        store(A_CTRL, 32'h0000_0004);
        chk("irq_lag", 32'(irq), 32'h0);
        tick();
        chk("irq_on", 32'(irq), 32'h1);
        rd("irq_ctrl", A_CTRL, 32'h0000_0004);
        push_word(32'h0000_0055);
        chk("irq_hold", 32'(irq), 32'h1);
        tick();
        chk("irq_off", 32'(irq), 32'h0);
        drain("irq_drain", 1);
        store(A_CTRL, 32'h0000_0000);
`endif

        // Reset in the middle of traffic drops everything, overflow included
        for (int i = 0; i < 8; i++) begin
            push_word(32'h0000_00D0 + 32'(i));
        end
        store(A_DATA, 32'h0000_00DE);
        rd("pre_rst_status", A_STAT, 32'h0000_0805);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(tx_valid), 32'h0);
        chk("mid_rst_data", tx_data, 32'h0);
        rd("mid_rst_status", A_STAT, 32'h0000_0002);
        exp_q.delete();
        @(negedge clk) reset = 1'b1;
        tick();
        push_word(32'h0000_00E0);
        drain("post_rst_drain", 1);
        rd("end_status", A_STAT, 32'h0000_0002);
        chk("end_q", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
